// File: rtl/ram32k_arbiter.sv
// Two-port front end for a single RAM32K: round-robin grant with an A-side lock
// for read-modify-write, and one-cycle tagged read-valid return to each port.
module ram32k_arbiter #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [0:DW-1] a_wdata,
  output logic          a_ack,
  output logic          a_rvalid,
  output logic [0:DW-1] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [0:DW-1] b_wdata,
  output logic          b_ack,
  output logic          b_rvalid,
  output logic [0:DW-1] b_rdata,
  output logic [0:DW-1] ram_data,
  output logic          ram_load,
  output logic [AW-1:0] ram_address,
  input  logic [0:DW-1] ram_out
);

  typedef enum logic [1:0] {
    PRIO_A = 2'd0,
    PRIO_B = 2'd1,
    LOCK_A = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   grant_a, grant_b;
  logic   a_rvalid_q, a_rvalid_d;
  logic   b_rvalid_q, b_rvalid_d;

  always_comb begin
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    state_d     = state_q;
    ram_load    = 1'b0;
    ram_address = '0;
    ram_data    = '0;

    case (state_q)
      PRIO_A: begin
        if (a_req)      grant_a = 1'b1;
        else if (b_req) grant_b = 1'b1;
      end
      PRIO_B: begin
        if (b_req)      grant_b = 1'b1;
        else if (a_req) grant_a = 1'b1;
      end
      LOCK_A:  grant_a = a_req;
      default: ;
    endcase

    // Reset is asynchronous, so no request may reach the RAM while it is held.
    if (!rst_n) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end

    if (grant_a)                               state_d = a_lock ? LOCK_A : PRIO_B;
    else if (grant_b)                          state_d = PRIO_A;
    else if ((state_q == LOCK_A) && !a_lock)   state_d = PRIO_B;

    if (grant_a) begin
      ram_load    = a_we;
      ram_address = a_addr;
      ram_data    = a_wdata;
    end else if (grant_b) begin
      ram_load    = b_we;
      ram_address = b_addr;
      ram_data    = b_wdata;
    end

    a_ack      = grant_a;
    b_ack      = grant_b;
    a_rvalid_d = grant_a & ~a_we;
    b_rvalid_d = grant_b & ~b_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PRIO_A;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // The RAM's registered output is shared; the rvalid tag says whose it is.
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = ram_out;
  assign b_rdata  = ram_out;

endmodule
